// File: rtl/gcd_controller.sv
// Control FSM for the subtractive 4-bit GCD engine.
// It steers the gcd_datapath from the eqflg/itflg flags and has an iteration watchdog.
module gcd_controller #(
  parameter int unsigned MAX_ITER = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic eqflg,
  input  logic itflg,
  output logic xmsel,
  output logic ymsel,
  output logic xld,
  output logic yld,
  output logic gld,
  output logic ready,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    SUBX  = 3'd3,
    SUBY  = 3'd4,
    GLD   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      iter_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  // The eq test comes before the watchdog test, so a match on the last
  // allowed iteration still reports a result.
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    unique case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD: begin
        iter_cnt_d = '0;
        state_d    = CHECK;
      end
      CHECK: begin
        if (eqflg)                         state_d = GLD;
        else if (iter_cnt_q == ITER_LIMIT) state_d = ERR;
        else if (itflg)                    state_d = SUBY;
        else                               state_d = SUBX;
      end
      SUBX, SUBY: begin
        if (iter_cnt_q != ITER_LIMIT) iter_cnt_d = iter_cnt_q + CNT_W'(1);
        state_d = CHECK;
      end
      GLD:   state_d = DONE;
      DONE:  state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    xmsel = 1'b0;
    ymsel = 1'b0;
    xld   = 1'b0;
    yld   = 1'b0;
    gld   = 1'b0;
    ready = 1'b0;
    done  = 1'b0;
    err   = 1'b0;
    unique case (state_q)
      IDLE:  ready = 1'b1;
      LOAD: begin
        xmsel = 1'b1;
        ymsel = 1'b1;
        xld   = 1'b1;
        yld   = 1'b1;
      end
      CHECK: ;
      SUBX:  xld  = 1'b1;
      SUBY:  yld  = 1'b1;
      GLD:   gld  = 1'b1;
      DONE:  done = 1'b1;
      ERR:   err  = 1'b1;
      default: ;
    endcase
  end

endmodule
